// File: rtl/ppu_pkg.sv
// Shared PPU types for the sprite line buffer: OAM entry layout, hit payload and scan states.
package ppu_pkg;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] attrs;
        logic [7:0] tile;
    } oam_entry_t;

    typedef struct packed {
        logic [2:0] row;
        logic [7:0] tile;
        logic [3:0] attrs;
    } sprite_data_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_READY = 2'd2
    } scan_state_t;

    // Row offset of ly inside a sprite whose OAM y is biased by 16.
    function automatic logic [7:0] sprite_dy(input logic [7:0] ly, input logic [7:0] y);
        return ly - y + 8'd16;
    endfunction

endpackage

// File: rtl/sprite_slot_n.sv
// One sprite slot: occupied flag plus stored x and fetch descriptor.
module sprite_slot_n
    import ppu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         pop,
    input  logic [7:0]   x_in,
    input  sprite_data_t data_in,
    output logic         occ,
    output logic [7:0]   x,
    output sprite_data_t data
);

    // A new scan (clr) overrides any load or pop arriving on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= 1'b0;
            x    <= '0;
            data <= '0;
        end else if (clr) begin
            occ <= 1'b0;
        end else if (load) begin
            occ  <= 1'b1;
            x    <= x_in;
            data <= data_in;
        end else if (pop) begin
            occ <= 1'b0;
        end
    end

endmodule

// File: rtl/sprite_line_buffer.sv
// OAM scanner and per-line sprite store; walks OAM on start, then answers lx queries in OAM order.
// Optional Y-flip of the selected row is enabled by defining SPRITE_YFLIP_EN.
module sprite_line_buffer
    import ppu_pkg::*;
#(
    parameter int SLOTS       = 10,
    parameter int OAM_ENTRIES = 40,
    localparam int AW = $clog2(2*OAM_ENTRIES),
    localparam int CW = $clog2(SLOTS+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    ly,
    input  logic          tall,
    output logic [AW-1:0] oam_addr,
    input  logic [15:0]   oam_d_in,
    output logic          scan_done,
    output logic          overflow,
    input  logic [7:0]    q_x,
    input  logic          q_pop,
    output logic          hit,
    output logic [14:0]   hit_data,
    output logic [CW-1:0] count,
    output scan_state_t   dbg_state
);

    localparam int SW = $clog2(2*OAM_ENTRIES+1);
    localparam logic [SW-1:0] LAST_CNT  = SW'(2*OAM_ENTRIES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(2*OAM_ENTRIES-1);

    // Handshake: start is a one-cycle request honoured in any state; scan_done pulses
    // for one cycle on the final scan cycle and results are queryable from the next.

    scan_state_t  state;
    logic [SW-1:0] scan_cnt;
    logic [15:0]  even_q;
    oam_entry_t   entry;
    logic [7:0]   dy;
    logic [3:0]   row_dy;
    logic [7:0]   x_store;
    logic         visible;
    logic         eval;
    logic         any_free;
    logic         pop_any;
    sprite_data_t new_data;
    logic [SLOTS-1:0] occ;
    logic [SLOTS-1:0] load_oh;
    logic [SLOTS-1:0] pop_oh;
    logic [7:0]   slot_x    [SLOTS];
    sprite_data_t slot_data [SLOTS];

    // Scan cycle k carries the word addressed in cycle k-1, so odd words land on even k.
    assign entry   = {even_q, oam_d_in};
    assign eval    = (state == S_SCAN) && !scan_cnt[0] && (scan_cnt != '0);
    assign dy      = sprite_dy(ly, entry.y);
    assign visible = tall ? (dy < 8'd16) : (dy < 8'd8);
    assign x_store = entry.x - 8'd8;

`ifdef SPRITE_YFLIP_EN
    assign row_dy = entry.attrs[6] ? ((tall ? 4'd15 : 4'd7) - dy[3:0]) : dy[3:0];
`else
    assign row_dy = dy[3:0];
`endif

    assign new_data = {row_dy[2:0], (tall ? {entry.tile[7:1], row_dy[3]} : entry.tile),
                       entry.attrs[7:4]};

    always_comb begin
        load_oh  = '0;
        any_free = 1'b0;
        pop_oh   = '0;
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!occ[i] && !any_free) begin
                load_oh[i] = eval && visible;
                any_free   = 1'b1;
            end
            if (state == S_READY && occ[i] && slot_x[i] == q_x && !hit) begin
                hit       = 1'b1;
                hit_data  = slot_data[i];
                pop_oh[i] = q_pop && !start;
            end
        end
    end

    assign pop_any   = |pop_oh;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            scan_cnt  <= '0;
            oam_addr  <= '0;
            even_q    <= '0;
            scan_done <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else if (start) begin
            state     <= S_SCAN;
            scan_cnt  <= '0;
            oam_addr  <= '0;
            scan_done <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (oam_addr != LAST_ADDR) oam_addr <= oam_addr + AW'(1);
                    scan_cnt  <= scan_cnt + SW'(1);
                    scan_done <= (scan_cnt == LAST_CNT - SW'(1));
                    if (scan_cnt[0]) even_q <= oam_d_in;
                    if (eval && visible) begin
                        if (any_free) count <= count + CW'(1);
                        else          overflow <= 1'b1;
                    end
                    if (scan_cnt == LAST_CNT) state <= S_READY;
                end
                S_READY: begin
                    if (pop_any) count <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        sprite_slot_n u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (start),
            .load    (load_oh[g]),
            .pop     (pop_oh[g]),
            .x_in    (x_store),
            .data_in (new_data),
            .occ     (occ[g]),
            .x       (slot_x[g]),
            .data    (slot_data[g])
        );
    end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Randomised bench for sprite_line_buffer against an OAM-order sprite list model.
module tb_sprite_line_buffer;
    import ppu_pkg::*;

    localparam int SLOTS = 10;
    localparam int N     = 40;

    logic        clk = 1'b0;
    logic        rst, start, tall, q_pop;
    logic [7:0]  ly, q_x;
    logic [15:0] oam_d_in;
    logic [6:0]  oam_addr;
    logic        scan_done, overflow, hit;
    logic [14:0] hit_data;
    logic [3:0]  count;
    scan_state_t dbg_state;

    sprite_line_buffer #(.SLOTS(SLOTS), .OAM_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ly(ly), .tall(tall),
        .oam_addr(oam_addr), .oam_d_in(oam_d_in), .scan_done(scan_done),
        .overflow(overflow), .q_x(q_x), .q_pop(q_pop), .hit(hit),
        .hit_data(hit_data), .count(count), .dbg_state(dbg_state)
    );

    // clock / OAM memory
    always #5 clk = ~clk;

    logic [15:0] mem [2*N];
    always @(posedge clk) oam_d_in <= mem[oam_addr];

    // scoreboard: stored sprites in OAM order
    int          vec = 0;
    int          mis = 0;
    logic        chk_en = 1'b0;
    logic [7:0]  exp_x[$];
    logic [14:0] exp_q[$];
    logic        exp_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_x(input logic [7:0] x);
        foreach (exp_x[i]) if (exp_x[i] == x) return i;
        return -1;
    endfunction

    task automatic set_spr(input int k, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] attr, input logic [7:0] tile);
        mem[2*k]   = {x, y};
        mem[2*k+1] = {attr, tile};
    endtask

    task automatic clear_oam();
        for (int k = 0; k < N; k++) set_spr(k, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic build_model();
        exp_x.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            int x, y, at, tl, dy, rdy, lim;
            x   = int'(mem[2*k][15:8]);
            y   = int'(mem[2*k][7:0]);
            at  = int'(mem[2*k+1][15:8]);
            tl  = int'(mem[2*k+1][7:0]);
            dy  = (int'(ly) - y + 16 + 256) % 256;
            lim = tall ? 16 : 8;
            if (dy < lim) begin
                rdy = dy;
`ifdef SPRITE_YFLIP_EN
                if (((at >> 6) & 1) == 1) rdy = lim - 1 - dy;
`endif
                if (exp_x.size() < SLOTS) begin
                    exp_x.push_back(8'((x + 248) % 256));
                    exp_q.push_back({3'(rdy % 8),
                                     (tall ? 8'((tl & 254) | (rdy / 8)) : 8'(tl)),
                                     4'(at / 16)});
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    // compare process: every READY cycle
    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            idx = find_x(q_x);
            chk("hit", hit, idx >= 0);
            chk("hit_data", hit_data, (idx >= 0) ? exp_q[idx] : 15'd0);
            chk("count", count, exp_x.size());
            chk("overflow", overflow, exp_ovf);
        end
    end

    // driver tasks (entered at posedge+1)
    task automatic run_scan(input logic [7:0] lyv, input logic tv);
        int n;
        chk_en = 1'b0;
        ly = lyv;
        tall = tv;
        build_model();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("oam_addr_after_start", oam_addr, 0);
        n = 1;
        while (!scan_done && n < 200) begin
            if (exp_x.size() > 0) q_x = exp_x[0];
            chk("hit_during_scan", hit, 0);
            @(posedge clk);
            #1 n++;
        end
        chk("scan_done_latency", n, 81);
        @(posedge clk);
        #1;
        chk("scan_done_pulse", scan_done, 0);
        chk("state_ready", dbg_state, S_READY);
        chk_en = 1'b1;
    endtask

    task automatic rd(input logic [7:0] x, input logic pop);
        q_x = x;
        q_pop = pop;
        @(posedge clk);
        if (pop) begin
            int idx;
            idx = find_x(x);
            if (idx >= 0) begin
                exp_x.delete(idx);
                exp_q.delete(idx);
            end
        end
        #1 q_pop = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oam_addr"}, oam_addr, 0);
        chk({tag, "_scan_done"}, scan_done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_hit_data"}, hit_data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; ly = 8'd0; tall = 1'b0; q_x = 8'd0; q_pop = 1'b0;
        clear_oam();
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // three sprites, two sharing x
        clear_oam();
        set_spr(0, 8'd20, 8'd66, 8'h10, 8'h11);
        set_spr(1, 8'd50, 8'd66, 8'h20, 8'h22);
        set_spr(2, 8'd20, 8'd66, 8'h30, 8'h33);
        run_scan(8'd50, 1'b0);
        chk("t1_count", count, 3);
        q_x = 8'd12; #1 chk("t1_first", hit_data, 15'h0111);
        rd(8'd12, 1'b1);
        q_x = 8'd12; #1 chk("t1_second", hit_data, 15'h0333);
        rd(8'd12, 1'b1);
        q_x = 8'd12; #1 chk("t1_empty", hit, 0);
        q_x = 8'd42; #1 chk("t1_other", hit_data, 15'h0222);
        rd(8'd99, 1'b1);
        rd(8'd42, 1'b0);

        // overflow: twelve visible sprites
        clear_oam();
        for (int k = 0; k < 12; k++)
            set_spr(k, 8'(30 + 10*k), 8'(96 - (k % 8)), 8'(k << 4), 8'(k));
        run_scan(8'd80, 1'b0);
        chk("t2_count", count, 10);
        chk("t2_overflow", overflow, 1);
        q_x = 8'd122; #1 chk("t2_oam10_absent", hit, 0);
        q_x = 8'd132; #1 chk("t2_oam11_absent", hit, 0);
        for (int k = 0; k < 12; k++) rd(8'(22 + 10*k), 1'b1);

        // tall sprite, dy = 9
        clear_oam();
        set_spr(0, 8'd60, 8'd107, 8'h40, 8'h35);
        set_spr(1, 8'd70, 8'd107, 8'h00, 8'h35);
        run_scan(8'd100, 1'b1);
        q_x = 8'd52;
`ifdef SPRITE_YFLIP_EN
        #1 chk("t3_tall_flip", hit_data, 15'h6344);
`else
        #1 chk("t3_tall", hit_data, 15'h1354);
`endif
        q_x = 8'd62; #1 chk("t3_tall_noflip", hit_data, 15'h1350);
        rd(8'd62, 1'b0);

        // sprite at x=4 stores 252 and never matches visible lx
        clear_oam();
        set_spr(0, 8'd4, 8'd46, 8'h50, 8'h77);
        run_scan(8'd30, 1'b0);
        chk("t4_count", count, 1);
        for (int x = 0; x < 160; x++) rd(8'(x), 1'b0);
        q_x = 8'd252; #1 chk("t4_wrap_hit", hit, 1);
        rd(8'd252, 1'b0);

        // restart mid-scan at oam_addr 30
        clear_oam();
        set_spr(0, 8'd20, 8'd66, 8'h10, 8'h11);
        set_spr(1, 8'd50, 8'd66, 8'h20, 8'h22);
        set_spr(2, 8'd20, 8'd66, 8'h30, 8'h33);
        chk_en = 1'b0;
        ly = 8'd50; tall = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            int n;
            n = 0;
            while (oam_addr != 7'd30 && n < 100) begin
                @(posedge clk);
                #1 n++;
            end
            chk("t5_reach_addr30", oam_addr, 30);
        end
        run_scan(8'd50, 1'b0);
        chk("t5_count", count, 3);
        rd(8'd12, 1'b1);
        rd(8'd42, 1'b0);

        // reset during READY with five stored sprites
        clear_oam();
        for (int k = 0; k < 5; k++) set_spr(k, 8'(40 + 8*k), 8'd136, 8'h00, 8'(k));
        run_scan(8'd120, 1'b0);
        chk("t6_count", count, 5);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("t6_async");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("t6_stays_idle", dbg_state, S_IDLE);

        // randomised lines
        for (int r = 0; r < 12; r++) begin
            logic [7:0] lyv;
            logic       tv;
            lyv = 8'($urandom_range(0, 200));
            tv  = 1'($urandom_range(0, 1));
            clear_oam();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int dy;
                    dy = $urandom_range(0, tv ? 15 : 7);
                    set_spr(k, 8'($urandom_range(8, 40)), 8'(int'(lyv) + 16 - dy),
                            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end else begin
                    mem[2*k] = {8'($urandom_range(0, 255)), 8'd0};
                end
            end
            run_scan(lyv, tv);
            for (int c = 0; c < 30; c++) begin
                logic [7:0] x;
                if (exp_x.size() > 0 && $urandom_range(0, 3) != 0)
                    x = exp_x[$urandom_range(0, exp_x.size() - 1)];
                else
                    x = 8'($urandom_range(0, 255));
                rd(x, 1'($urandom_range(0, 1)));
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/sprite_line_buffer.md
# sprite_line_buffer

Parametrised OAM scanner and per-line sprite store for the PPU, the next generation of the fixed 10-slot sprite chain. At the start of each scanline it walks OAM, selects up to `SLOTS` sprites visible on `ly`, and holds them for the draw phase. During draw the renderer presents its current `lx` and receives the matching sprite fetch descriptor, lowest OAM index first. Adds configurable depth, an overflow flag, explicit scan handshakes and optional Y-flip.

## Interface
Parameters:
- `SLOTS`, 10, sprite slots per line (1..16)
- `OAM_ENTRIES`, 40, OAM entries scanned (power of two not required)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: pulse, begin scan for `ly`
- `ly` in 8: current scanline, sampled every scan cycle
- `tall` in 1: 8x16 sprites when 1, else 8x8
- `oam_addr` out $clog2(2*OAM_ENTRIES): OAM word address
- `oam_d_in` in 16: OAM word, valid one cycle after `oam_addr`
- `scan_done` out 1: one-cycle pulse at end of scan
- `overflow` out 1: more than `SLOTS` visible sprites found this line
- `q_x` in 8: query x (renderer `lx`)
- `q_pop` in 1: consume the current hit
- `hit` out 1: a stored sprite matches `q_x` (combinational)
- `hit_data` out 15: {row[2:0], tile[7:0], attrs[3:0]} of the hit
- `count` out $clog2(SLOTS+1): slots currently occupied

## Operation
- OAM word layout: word 2k = {x, y}, word 2k+1 = {attrs, tile} (high byte first).
- States: IDLE, SCAN, READY. Reset -> IDLE.
- IDLE --start--> SCAN: clear all slots, `count`=0, `overflow`=0, `oam_addr`=0.
- SCAN: `oam_addr` increments each cycle to 2*OAM_ENTRIES-1; even word buffered; on the cycle the odd word arrives the entry is evaluated.
- dy = (ly - (y - 16)) mod 256; visible iff dy < 16 (tall) or dy < 8.
- Visible entry stored in lowest free slot; stored x = (x - 8) mod 256. If all slots full, entry dropped and `overflow` set.
- tile: tall -> {tile[7:1], row_dy[3]}; else tile unchanged. row = row_dy[2:0]. attrs = OAM attrs[7:4].
- After last entry evaluated: `scan_done` pulses, -> READY.
- READY: `hit` = any occupied slot with stored x == `q_x`; among matches, lowest slot (= lowest OAM index) drives `hit_data`. `q_pop` with `hit` frees that slot, `count` decrements. `q_pop` without `hit` ignored.
- `start` in any state restarts the scan (clears slots, overflow). `start` wins over a simultaneous `q_pop`.
- `q_pop` outside READY ignored; `hit`=0 outside READY.
- Sprites with x<8 store 248..255 and never match `lx` 0..159; not an error.

## Timing
- Reset values: `oam_addr`=0, `scan_done`=0, `overflow`=0, `hit`=0, `hit_data`=0, `count`=0.
- `oam_addr`=0 on the cycle after `start`; scan occupies 2*OAM_ENTRIES+1 cycles; `scan_done` high on the last, READY next cycle (81 cycles at default).
- `hit`/`hit_data` combinational from `q_x` and slot state, zero latency; slot freed on the `q_pop` edge, next match visible the following cycle.
- `count` and `overflow` update on the edge the entry is evaluated.

## Configuration
- `SPRITE_YFLIP_EN` defined: attrs[6] (Y-flip) set -> row_dy = (tall ? 15 : 7) - dy, applied before tile-bit and row selection.
- Undefined: row_dy = dy; attrs[6] passed through in `hit_data` only.

## Structure
- Shared package `ppu_pkg`: `oam_entry_t`, `sprite_data_t` (15-bit hit payload), scan state enum.
- One sub-module `sprite_slot_n`: single slot (occupied bit, x, data), load on select, clear on pop/start; instantiated `SLOTS` times with generate; priority select in the parent.

## Test plan
- 3 sprites y=16+ly, x=20,50,20 (OAM 0,1,2), 8x8 -> `count`=3 after `scan_done`; q_x=12 gives OAM 0 data, pop, then OAM 2 data, pop, then `hit`=0.
- 12 visible sprites, SLOTS=10 -> `count`=10, `overflow`=1, OAM 10/11 never returned.
- tall=1, tile=0x35, dy=9 -> tile=0x35, row=1; with `SPRITE_YFLIP_EN` and attrs=0x40 -> tile=0x34, row=6.
- Sprite x=4 visible -> stored 252, no hit for q_x 0..159.
- `start` asserted mid-scan at oam_addr=30 -> slots cleared, scan restarts at 0, `scan_done` 81 cycles after the second start.
- `rst` low during READY with count=5 -> outputs immediately at reset values, IDLE.
